call_responder: RTL and testbench
=================================

# call_responder

Attendant-side end of the room call-light link. It monitors the `light_state` outputs of N room call units and selects one lit room at a time by round-robin. It alerts the attendant, tracks acknowledge and service, and returns a one-cycle `cancel` pulse to the served room's call unit. An escalation timer flags any call left unacknowledged too long.

## Interface
- `N_ROOMS`, 4: number of room call units; must be ≥2.
- `ESC_CYCLES`, 16: ALERT cycles tolerated before `escalate`; must be ≥1.
- `RW`: derived, `$clog2(N_ROOMS)`; not user-set.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `light_state`  in  N_ROOMS  per-room call light; bit i comes from room i's call unit on the same `clk`.
- `ack`  in  1  attendant accepts the currently alerted call; level-sampled.
- `done`  in  1  attendant has finished service; level-sampled.
- `cancel`  out  N_ROOMS  one-hot, one-cycle pulse to the served room's `cancel` input.
- `active_room`  out  RW  index of the room being alerted or served.
- `alarm`  out  1  high while in ALERT.
- `busy`  out  1  high while in SERVE.
- `escalate`  out  1  unacknowledged-call timeout.

## Operation
- States: IDLE, ALERT, SERVE, CANCEL. All outputs are registered or Moore-decoded from the state registers.
- Reset values: state=IDLE, `ptr`=0, `active_room`=0, esc count=0, `cancel`=0, `alarm`=0, `busy`=0, `escalate`=0.
- A reset asserted in any state forces these values on the next edge. No `cancel` pulse is emitted on reset.
- IDLE:
  - If any `light_state` bit is set, select the first set index scanning `ptr`, `ptr+1`, … mod N_ROOMS.
  - Load that index into `active_room`, clear the esc count, and go to ALERT.
  - With no lights set, remain in IDLE.
- ALERT:
  - `alarm`=1.
  - If `light_state[active_room]`=0, the room cancelled locally. Go to IDLE; `ptr` is unchanged and no `cancel` pulse is emitted.
  - Else if `ack`=1, go to SERVE.
  - Else stay in ALERT; the esc count increments and saturates at ESC_CYCLES.
  - The light-drop check has priority over `ack`. `done` is ignored in ALERT.
- SERVE:
  - `busy`=1.
  - `ack` is ignored. Changes to `light_state` are ignored, including the served room's light dropping.
  - On `done`=1, go to CANCEL.
- CANCEL:
  - Lasts exactly one cycle. `cancel[active_room]`=1 and all other `cancel` bits are 0.
  - Set `ptr` = (`active_room`+1) mod N_ROOMS; wrap from N_ROOMS-1 to 0.
  - Go to IDLE unconditionally.
- Escalation:
  - `escalate`=1 only in ALERT, and only when the esc count equals ESC_CYCLES.
  - Esc count width: `$clog2(ESC_CYCLES+1)`.
  - `escalate` clears on the edge that leaves ALERT.
- `active_room` holds its last value in IDLE.
- `cancel` is zero in every state except CANCEL.

## Timing
- A light sampled high in IDLE at edge k gives ALERT, `alarm`, and a valid `active_room` from edge k+1.
- `ack` sampled at edge k in ALERT gives `busy` from edge k+1; `alarm` drops at the same edge.
- `done` sampled at edge k in SERVE gives `cancel` high for cycle k+1 → k+2, then IDLE from edge k+2.
- The room unit registers `cancel` at edge k+2, so its light is already low when IDLE first evaluates.
- If the room's call input is still held, its light stays high and the room is re-selected only after the other lit rooms, because `ptr` has advanced.
- Escalation timing:
  - The first ALERT cycle has count 0.
  - `escalate` rises at the start of ALERT cycle ESC_CYCLES+1, i.e. ESC_CYCLES edges after ALERT entry.
- Minimum call turnaround with `ack` and `done` each asserted one cycle after state entry: IDLE→ALERT→SERVE→CANCEL→IDLE in 4 cycles.

## Test plan
- Single call: `light_state`=0010 with N_ROOMS=4; `ack` on the 2nd ALERT cycle; `done` on the 3rd SERVE cycle. Expect:
  - `active_room`=1 and `alarm` for 2 cycles, then `busy` for 3 cycles.
  - `cancel`=0010 for exactly one cycle.
  - Return to IDLE with `ptr`=2.
- Round-robin fairness: all four lights held high, and each call is served by cycling `ack` then `done`. Expect served order 0,1,2,3,0; `ptr` wraps 3→0.
- Local cancel: room 2's light is alerted, then drops before `ack`. Expect:
  - ALERT→IDLE with no `cancel` pulse and `ptr` unchanged.
  - A lit room 3 is selected next.
- Escalation with ESC_CYCLES=16: hold room 0's light and never assert `ack`. Expect:
  - `escalate`=0 through ALERT cycle 16.
  - `escalate`=1 from cycle 17 and held.
  - `escalate` cleared the cycle after `ack`, with `busy`=1.
- Priority and simultaneity:
  - `ack` together with the room's light dropping in ALERT → IDLE.
  - `ack` and `done` together in ALERT → SERVE, with `done` ignored.
  - `ack` in SERVE → no effect.
- Reset mid-operation: assert `reset` in SERVE, and separately in CANCEL. Expect every output at its reset value the next cycle, state IDLE and `ptr`=0. When reset lands in CANCEL, `cancel` is forced to 0 at that edge, so the pulse lasts at most the cycle already in progress.

Source files
------------

// File: rtl/call_responder.sv
// call_responder: round-robin call-light selector with ack/serve tracking, cancel pulse and escalation timer.
module call_responder #(
  parameter int N_ROOMS = 4,
  parameter int ESC_CYCLES = 16,
  localparam int RW = $clog2(N_ROOMS),
  localparam int EW = $clog2(ESC_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_ROOMS-1:0] light_state,
  input  logic               ack,
  input  logic               done,
  output logic [N_ROOMS-1:0] cancel,
  output logic [RW-1:0]      active_room,
  output logic               alarm,
  output logic               busy,
  output logic               escalate
);
  typedef enum logic [1:0] {IDLE, ALERT, SERVE, CANCEL} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] ptr_q, ptr_d, room_q, room_d, pick;
  logic [EW-1:0] esc_q, esc_d;
  logic hit;
  function automatic logic [RW-1:0] wrap(input logic [RW:0] s);
    return RW'(s >= (RW+1)'(N_ROOMS) ? s - (RW+1)'(N_ROOMS) : s);
  endfunction
  // Scan downward so the lit room nearest ptr is the last assignment and wins.
  always_comb begin
    hit = 1'b0;
    pick = ptr_q;
    for (int i = N_ROOMS - 1; i >= 0; i--) begin
      if (light_state[wrap({1'b0, ptr_q} + (RW+1)'(i))]) begin
        hit = 1'b1;
        pick = wrap({1'b0, ptr_q} + (RW+1)'(i));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      room_q <= '0;
      esc_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      room_q <= room_d;
      esc_q <= esc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    room_d = room_q;
    esc_d = esc_q;
    case (state_q)
      IDLE: if (hit) begin
        state_d = ALERT;
        room_d = pick;
        esc_d = '0;
      end
      ALERT: begin
        state_d = !light_state[room_q] ? IDLE : ack ? SERVE : ALERT;
        esc_d = esc_q == EW'(ESC_CYCLES) ? esc_q : esc_q + 1'b1;
      end
      SERVE: state_d = done ? CANCEL : SERVE;
      default: begin
        state_d = IDLE;
        ptr_d = room_q == RW'(N_ROOMS - 1) ? '0 : room_q + 1'b1;
      end
    endcase
  end
  always_comb begin
    alarm = state_q == ALERT;
    busy = state_q == SERVE;
    escalate = state_q == ALERT && esc_q == EW'(ESC_CYCLES);
    cancel = state_q == CANCEL ? N_ROOMS'(1) << room_q : '0;
    active_room = room_q;
  end
endmodule

// File: tb/tb_call_responder.sv
// tb_call_responder: directed checks of selection, serve flow, local cancel, escalation and reset.
module tb_call_responder;
  logic clk = 1'b0, reset = 1'b1, ack = 1'b0, done = 1'b0;
  logic [3:0] light_state = '0, cancel;
  logic [1:0] active_room;
  logic alarm, busy, escalate;
  int total = 0, bad = 0;
  call_responder #(.N_ROOMS(4), .ESC_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .light_state(light_state), .ack(ack), .done(done),
    .cancel(cancel), .active_room(active_room), .alarm(alarm), .busy(busy), .escalate(escalate)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [1:0] r, input logic [3:0] c, input logic a, input logic b, input logic e);
    logic [8:0] obs, exp;
    obs = {active_room, cancel, alarm, busy, escalate};
    exp = {r, c, a, b, e};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed room/cancel/alarm/busy/esc=%b required=%b", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("reset", 2'd0, 4'b0000, 0, 0, 0);
    reset = 1'b0;
    light_state = 4'b0010;
    tick(); chk("single_alert1", 2'd1, 4'b0000, 1, 0, 0);
    tick(); chk("single_alert2", 2'd1, 4'b0000, 1, 0, 0);
    ack = 1'b1;
    tick(); chk("single_serve1", 2'd1, 4'b0000, 0, 1, 0);
    ack = 1'b0;
    tick(); chk("single_serve2", 2'd1, 4'b0000, 0, 1, 0);
    tick(); chk("single_serve3", 2'd1, 4'b0000, 0, 1, 0);
    done = 1'b1;
    tick(); chk("single_cancel", 2'd1, 4'b0010, 0, 0, 0);
    done = 1'b0; light_state = 4'b0000;
    tick(); chk("single_idle", 2'd1, 4'b0000, 0, 0, 0);
    light_state = 4'b1111;
    tick(); chk("ptr_is_2", 2'd2, 4'b0000, 1, 0, 0);
    reset = 1'b1;
    tick(); chk("reset2", 2'd0, 4'b0000, 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] r;
      r = 2'(k);
      tick(); chk("rr_alert", r, 4'b0000, 1, 0, 0);
      ack = 1'b1;
      tick(); chk("rr_serve", r, 4'b0000, 0, 1, 0);
      ack = 1'b0; done = 1'b1;
      tick(); chk("rr_cancel", r, 4'b0001 << r, 0, 0, 0);
      done = 1'b0;
      tick(); chk("rr_idle", r, 4'b0000, 0, 0, 0);
    end
    light_state = 4'b0000;
    tick(); chk("idle_dark", 2'd0, 4'b0000, 0, 0, 0);
    light_state = 4'b0100;
    tick(); chk("local_alert", 2'd2, 4'b0000, 1, 0, 0);
    light_state = 4'b1000;
    tick(); chk("local_drop", 2'd2, 4'b0000, 0, 0, 0);
    tick(); chk("local_next", 2'd3, 4'b0000, 1, 0, 0);
    ack = 1'b1; light_state = 4'b0000;
    tick(); chk("drop_beats_ack", 2'd3, 4'b0000, 0, 0, 0);
    ack = 1'b0; light_state = 4'b0001;
    tick(); chk("sim_alert", 2'd0, 4'b0000, 1, 0, 0);
    ack = 1'b1; done = 1'b1;
    tick(); chk("ack_done_alert", 2'd0, 4'b0000, 0, 1, 0);
    ack = 1'b0; done = 1'b0;
    tick(); chk("done_ignored", 2'd0, 4'b0000, 0, 1, 0);
    ack = 1'b1; light_state = 4'b0000;
    tick(); chk("ack_in_serve", 2'd0, 4'b0000, 0, 1, 0);
    ack = 1'b0; done = 1'b1;
    tick(); chk("sim_cancel", 2'd0, 4'b0001, 0, 0, 0);
    done = 1'b0;
    tick(); chk("sim_idle", 2'd0, 4'b0000, 0, 0, 0);
    light_state = 4'b0001;
    tick();
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("esc_low_c%0d", c), 2'd0, 4'b0000, 1, 0, 0);
      tick();
    end
    chk("esc_c17", 2'd0, 4'b0000, 1, 0, 1);
    tick(); chk("esc_c18", 2'd0, 4'b0000, 1, 0, 1);
    ack = 1'b1;
    tick(); chk("esc_clear", 2'd0, 4'b0000, 0, 1, 0);
    ack = 1'b0; done = 1'b1;
    tick(); chk("esc_cancel", 2'd0, 4'b0001, 0, 0, 0);
    done = 1'b0; light_state = 4'b0000;
    tick(); chk("esc_idle", 2'd0, 4'b0000, 0, 0, 0);
    light_state = 4'b0100;
    tick(); chk("rs_alert", 2'd2, 4'b0000, 1, 0, 0);
    ack = 1'b1;
    tick(); chk("rs_serve", 2'd2, 4'b0000, 0, 1, 0);
    ack = 1'b0; reset = 1'b1;
    tick(); chk("reset_in_serve", 2'd0, 4'b0000, 0, 0, 0);
    reset = 1'b0; light_state = 4'b0011;
    tick(); chk("ptr0_after_serve_reset", 2'd0, 4'b0000, 1, 0, 0);
    light_state = 4'b0010;
    tick(); chk("rc_drop", 2'd0, 4'b0000, 0, 0, 0);
    tick(); chk("rc_alert", 2'd1, 4'b0000, 1, 0, 0);
    ack = 1'b1;
    tick(); chk("rc_serve", 2'd1, 4'b0000, 0, 1, 0);
    ack = 1'b0; done = 1'b1;
    tick(); chk("rc_cancel", 2'd1, 4'b0010, 0, 0, 0);
    done = 1'b0; reset = 1'b1;
    tick(); chk("reset_in_cancel", 2'd0, 4'b0000, 0, 0, 0);
    reset = 1'b0; light_state = 4'b0110;
    tick(); chk("ptr0_after_cancel_reset", 2'd1, 4'b0000, 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
